instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Multicycle instruction fetch stage directly upstream of MainDecoder/ALUDecoder.
//  Owns the PC, issues one read per instruction to instruction memory over a
//  ren/rvalid handshake, and presents instr + instr_pc to decode with valid/ready.
//  Accepts a one-cycle redirect (branch/jump target) and squashes stale fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded by reset; first fetch address
// PORTS
//  clock        in   1   single clock, all state updates on posedge
//  reset        in   1   synchronous, active-high
//  mem_ren      out  1   read request to instruction memory, 1 cycle per fetch
//  mem_addr     out  32  read address, word aligned, held stable from REQ until response
//  mem_rdata    in   32  read data, sampled only when mem_rvalid=1 in WAIT/DRAIN
//  mem_rvalid   in   1   read response strobe, 1 cycle, earliest 1 cycle after mem_ren
//  instr        out  32  fetched instruction word to decode
//  instr_pc     out  32  address of instr
//  instr_valid  out  1   instr/instr_pc valid
//  instr_ready  in   1   decode accepts; transfer when instr_valid & instr_ready
//  redirect     in   1   1-cycle pulse: next fetch from redirect_pc
//  redirect_pc  in   32  new fetch address
//  fetch_err    out  1   misaligned redirect (FETCH_ALIGN_CHECK_EN only)
// BEHAVIOUR
//  - Reset (any state, any cycle): state=IDLE, pc=RESET_PC, mem_ren=0,
//    mem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_err=0.
//    Instruction memory shares this reset; no response survives it.
//  - States: IDLE, REQ, WAIT, HOLD, DRAIN, HALT. All outputs registered;
//    mem_ren = (state==REQ), a decode of the state register only.
//  - IDLE -> REQ on first cycle out of reset.
//  - REQ: mem_ren=1, mem_addr=pc; -> WAIT. rvalid in REQ is ignored.
//  - WAIT: on mem_rvalid, instr<=mem_rdata, instr_pc<=pc, instr_valid<=1,
//    pc<=pc+4, -> HOLD. No timeout.
//  - HOLD: instr, instr_pc stable while instr_valid & !instr_ready.
//    On instr_ready: instr_valid<=0, -> REQ. Throughput: 1 instr per 2+L cycles,
//    where L = memory latency (>=1).
//  - DRAIN: wait for the in-flight response, discard it, -> REQ.
//  - redirect (priority over all except reset), pc<=redirect_pc, instr_valid<=0:
//    IDLE/HOLD -> REQ. A same-cycle instr_ready in HOLD still counts as accepted.
//    REQ -> DRAIN.
//    WAIT with no rvalid -> DRAIN.
//    WAIT with same-cycle rvalid -> REQ; that response is discarded.
//    DRAIN -> stays DRAIN; only the latest redirect_pc is kept.
//  - pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0, no flag.
//  - At most one outstanding memory read at any time.
//  - rvalid in IDLE/HOLD/HALT is a memory protocol error; it is ignored.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//    a redirect with redirect_pc[1:0]!=0 sets fetch_err=1 (sticky until reset)
//    and sets instr_valid<=0. State -> HALT, where mem_ren stays 0 and no
//    further fetches occur. An in-flight response is discarded.
//    A redirect in HALT is ignored.
//  FETCH_ALIGN_CHECK_EN undefined:
//    redirect_pc[1:0] is forced to 2'b00, fetch_err is tied 0, and HALT is
//    unreachable.
// TESTING
//  1 reset 2 cycles, memory L=1 returns 32'h012A_4020, ready=1 ->
//    mem_ren at cycle 1 with addr 0; instr_valid with instr=32'h012A_4020,
//    instr_pc=0; next mem_addr=4.
//  2 ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, mem_ren=0
//    throughout; ready=1 -> next request issued the following cycle.
//  3 redirect to 32'h40 in WAIT, memory L=3 -> stale response dropped,
//    instr_valid stays 0; next mem_addr=32'h40, instr_pc=32'h40.
//  4 redirect to 32'h80 in the same cycle as rvalid in WAIT -> data dropped,
//    REQ next cycle with mem_addr=32'h80.
//  5 redirect to 32'hFFFF_FFFC, fetch accepted -> next mem_addr=32'h0;
//    reset asserted in WAIT -> all outputs at reset values the next cycle.
//  6 redirect to 32'h42: macro defined -> fetch_err=1, mem_ren stays 0 for
//    20 cycles; macro undefined -> fetch from 32'h40, fetch_err=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: owns the PC, issues one memory read per
// instruction over ren/rvalid, and hands instr/instr_pc to decode with valid/ready.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise fetch_err and halt fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  // Redirect target as the fetch path sees it, and whether it must halt fetch.
  logic [31:0] redir_pc;
  logic        redir_bad;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;

  assign redir_pc  = redirect_pc;
  assign redir_bad = |redirect_pc[1:0];
  assign fetch_err = err_q;
`else
  // Without the check the low bits are simply dropped; HALT is never entered.
  logic unused_redirect_lsbs;

  assign redir_pc             = {redirect_pc[31:2], 2'b00};
  assign redir_bad            = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign fetch_err            = 1'b0;
`endif

  // The read strobe is a pure decode of the state register.
  assign mem_ren     = (state_q == S_REQ);
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

  // Next-state logic: redirect outranks the normal fetch sequence, HALT is terminal.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d         = err_q;
`endif

    if (redirect && (state_q != S_HALT)) begin
      // Any buffered instruction belongs to the old path; a same-cycle
      // handshake in HOLD has already been taken by decode, so dropping is safe.
      instr_valid_d = 1'b0;
      if (redir_bad) begin
`ifdef FETCH_ALIGN_CHECK_EN
        err_d   = 1'b1;
`endif
        state_d = S_HALT;
      end else begin
        pc_d = redir_pc;
        unique case (state_q)
          // A read is going out this cycle; its response must be swallowed.
          S_REQ:   state_d = S_DRAIN;
          // If the response lands this very cycle it is discarded here and no
          // read remains outstanding, so the new path can be fetched at once.
          S_WAIT:  state_d = mem_rvalid ? S_REQ : S_DRAIN;
          // Same reasoning in DRAIN: only keep draining while a read is still in flight.
          S_DRAIN: state_d = mem_rvalid ? S_REQ : S_DRAIN;
          default: state_d = S_REQ;
        endcase
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
        end
        S_REQ: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            instr_d       = mem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
            state_d       = S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
          end
        end
        S_DRAIN: begin
          if (mem_rvalid) begin
            state_d = S_REQ;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // The address is loaded only on entry to REQ so it stays put while a read is outstanding.
    if (state_d == S_REQ) begin
      mem_addr_d = pc_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random ready/redirect/latency traffic.
// A memory model answers reads; a monitor checks every decode transfer against a PC-stream model.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  always #5 clock = ~clock;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_ren     (mem_ren),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_err   (fetch_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int mem_lat  = 1;
  bit rand_lat = 1'b0;

  // Redirect targets issued by the stimulus, consumed by the monitor in order.
  logic [31:0] redir_q[$];

  // Memory contents: a fixed function of the address; word 0 is 32'h012A_4020.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h012A_4020 ^ (a * 32'h9E37_79B9);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    redir_q.push_back(t);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    chk1(name, instr_valid, 1'b1);
  endtask

  task automatic wait_ren(input string name);
    for (int i = 0; i < 20 && !mem_ren; i++) step();
    chk1(name, mem_ren, 1'b1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk1({tag, "_ren"},   mem_ren,     1'b0);
    chk ({tag, "_addr"},  mem_addr,    32'h0);
    chk ({tag, "_instr"}, instr,       32'h0);
    chk ({tag, "_ipc"},   instr_pc,    32'h0);
    chk1({tag, "_valid"}, instr_valid, 1'b0);
    chk1({tag, "_err"},   fetch_err,   1'b0);
  endtask

  // Instruction memory: one read at a time, answers after mem_lat cycles (or random 1..4).
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_req_addr = 32'h0;

  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clock);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (reset) begin
        mem_busy = 1'b0;
      end else begin
        if (mem_busy) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            chk("mem_addr_stable", mem_addr, mem_req_addr);
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(mem_req_addr);
            mem_busy   = 1'b0;
          end
        end
        if (mem_ren) begin
          chk1("one_outstanding", mem_busy, 1'b0);
          chk1("addr_aligned", |mem_addr[1:0], 1'b0);
          mem_busy     = 1'b1;
          mem_cnt      = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
          mem_req_addr = mem_addr;
        end
      end
    end
  end

  // Monitor: reference model of the architectural fetch stream.
  logic [31:0] model_pc   = 32'h0;
  bit          model_halt = 1'b0;
  bit          prev_hold  = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  logic [31:0] prev_pc    = 32'h0;

  initial begin
    logic [31:0] t;
    forever begin
      @(negedge clock);
      if (reset) begin
        model_pc   = 32'h0;
        model_halt = 1'b0;
        prev_hold  = 1'b0;
        redir_q.delete();
      end else begin
        chk1("fetch_err", fetch_err, model_halt);
        if (prev_hold) begin
          chk1("hold_valid", instr_valid, 1'b1);
          chk ("hold_instr", instr, prev_instr);
          chk ("hold_pc", instr_pc, prev_pc);
        end
        if (mem_ren) chk1("no_ren_while_valid", instr_valid, 1'b0);
        if (instr_valid && instr_ready) begin
          chk1("no_xfer_halted", model_halt, 1'b0);
          chk ("instr_pc", instr_pc, model_pc);
          chk ("instr", instr, mem_word(model_pc));
          n_xfer++;
          model_pc = model_pc + 32'd4;
        end
        prev_hold  = instr_valid && !instr_ready && !redirect;
        prev_instr = instr;
        prev_pc    = instr_pc;
        if (redirect) begin
          n_checks++;
          if (redir_q.size() == 0) begin
            n_fail++;
            $display("FAIL redir_queue: got empty expected pending target");
          end else begin
            t = redir_q.pop_front();
            if (!model_halt) begin
`ifdef FETCH_ALIGN_CHECK_EN
              if (t[1:0] != 2'b00) model_halt = 1'b1;
              else model_pc = t;
`else
              model_pc = {t[31:2], 2'b00};
`endif
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "time limit");
  end

  // Stimulus.
  initial begin
    logic [31:0] t;
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    chk_reset_values("rst");

    // Scenario 1: first fetch with L=1 and decode always ready.
    reset       = 1'b0;
    instr_ready = 1'b1;
    mem_lat     = 1;
    step();
    chk1("t1_ren", mem_ren, 1'b1);
    chk ("t1_addr", mem_addr, 32'h0);
    step();
    step();
    chk1("t1_valid", instr_valid, 1'b1);
    chk ("t1_instr", instr, 32'h012A_4020);
    chk ("t1_ipc", instr_pc, 32'h0);
    step();
    chk1("t1_ren2", mem_ren, 1'b1);
    chk ("t1_addr2", mem_addr, 32'h4);

    // Scenario 2: decode stalls five cycles in HOLD.
    instr_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk1("t2_valid", instr_valid, 1'b1);
      chk ("t2_ipc", instr_pc, 32'h4);
      chk ("t2_instr", instr, mem_word(32'h4));
      chk1("t2_ren", mem_ren, 1'b0);
      step();
    end
    instr_ready = 1'b1;
    step();
    chk1("t2_ren_next", mem_ren, 1'b1);
    chk ("t2_addr_next", mem_addr, 32'h8);

    // Scenario 3: redirect during WAIT with L=3; stale response dropped.
    mem_lat = 3;
    step();
    do_redirect(32'h40);
    step();
    redirect = 1'b0;
    mem_lat  = 1;
    for (int k = 0; k < 10 && !mem_ren; k++) begin
      chk1("t3_no_valid", instr_valid, 1'b0);
      step();
    end
    chk1("t3_ren", mem_ren, 1'b1);
    chk ("t3_addr", mem_addr, 32'h40);
    wait_valid("t3_valid");
    chk ("t3_ipc", instr_pc, 32'h40);
    chk ("t3_instr", instr, mem_word(32'h40));
    step();
    chk ("t3_addr_next", mem_addr, 32'h44);

    // Scenario 4: redirect coincides with rvalid in WAIT.
    step();
    do_redirect(32'h80);
    step();
    redirect = 1'b0;
    chk1("t4_ren", mem_ren, 1'b1);
    chk ("t4_addr", mem_addr, 32'h80);
    chk1("t4_valid", instr_valid, 1'b0);
    step();
    step();
    chk ("t4_ipc", instr_pc, 32'h80);
    step();

    // Scenario 5: PC wraps past the top of the address space, then reset in WAIT.
    do_redirect(32'hFFFF_FFFC);
    step();
    redirect = 1'b0;
    wait_valid("t5_valid");
    chk ("t5_ipc", instr_pc, 32'hFFFF_FFFC);
    step();
    chk1("t5_ren", mem_ren, 1'b1);
    chk ("t5_wrap_addr", mem_addr, 32'h0);
    step();
    reset = 1'b1;
    step();
    chk_reset_values("t5_rst");
    reset = 1'b0;

    // Scenario 6: misaligned redirect.
    step();
    step();
    step();
    step();
    do_redirect(32'h42);
    step();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk1("t6_err", fetch_err, 1'b1);
    chk1("t6_valid", instr_valid, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk1("t6_halt_ren", mem_ren, 1'b0);
      if (i == 5) do_redirect(32'h100);
      else redirect = 1'b0;
      step();
    end
    redirect = 1'b0;
    chk1("t6_err_sticky", fetch_err, 1'b1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
`else
    wait_ren("t6_ren");
    chk ("t6_addr", mem_addr, 32'h40);
    chk1("t6_err", fetch_err, 1'b0);
`endif

    // Random traffic: ready stalls, redirects in any state, latency 1..4.
    rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        t = $urandom;
        if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8;
`ifdef FETCH_ALIGN_CHECK_EN
        t[1:0] = 2'b00;
`else
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
`endif
        do_redirect(t);
      end else begin
        redirect = 1'b0;
      end
      step();
    end
    redirect    = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk1("progress", (n_xfer >= 200), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
